uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, byte width and parity helper.
// Used by both uart_receiver and uart_transmitter.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } uart_state_t;

    function automatic logic even_parity(input logic [BYTE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; rd_data is valid the cycle after a write, pops take effect on the next edge.
// Backpressure: a write while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int DEPTH = 1 << DEPTH_BITWIDTH;

    logic [BYTE_W-1:0]       mem [DEPTH];
    logic [DEPTH_BITWIDTH:0] wr_ptr;
    logic [DEPTH_BITWIDTH:0] rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    // Extra MSB on the pointers tells a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_BITWIDTH] != rd_ptr[DEPTH_BITWIDTH]) &&
                   (wr_ptr[DEPTH_BITWIDTH-1:0] == rd_ptr[DEPTH_BITWIDTH-1:0]);

    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    assign rd_data = empty ? '0 : mem[rd_ptr[DEPTH_BITWIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_BITWIDTH-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead FIFO; byte appears the cycle after the stop sample.
// Backpressure: none on the line; a byte arriving while the FIFO is full is dropped and flags overrun.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ            = 20_250_000,
    parameter int BAUD_RATE           = 2_025_000,
    parameter int FIFO_DEPTH_BITWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              framing_error,
`ifdef UART_RX_PARITY_EN
    output logic              parity_error,
`endif
    input  logic              err_clr
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] FULL_LD = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] HALF_LD = TW'(BIT_TICKS / 2);

    uart_state_t       state;
    uart_state_t       state_nxt;
    logic              rx_sync1;
    logic              rx_sync2;
    logic              rx_prev;
    logic              rx;
    logic              fall;
    logic              tick;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              push;
    logic              frame_err_set;
    logic              overrun_set;

    assign rx   = rx_sync2;
    assign fall = rx_prev & ~rx;
    assign tick = (timer == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_set;
`endif

    always_comb begin
        state_nxt     = state;
        push          = 1'b0;
        frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_set   = 1'b0;
`endif
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START:   if (tick) state_nxt = rx ? IDLE : DATA;
            DATA: begin
                if (tick && bit_cnt == 3'(BYTE_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            // A bad parity bit drops the byte; RECOVER skips over the stop bit.
            PARITY: begin
                if (tick) begin
                    if (rx != even_parity(shreg)) begin
                        par_err_set = 1'b1;
                        state_nxt   = RECOVER;
                    end else begin
                        state_nxt   = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_nxt     = RECOVER;
                    end
                end
            end
            RECOVER: if (rx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        timer   <= HALF_LD;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        timer   <= FULL_LD;
                        shreg   <= {rx, shreg[BYTE_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        timer   <= timer - 1'b1;
                    end
                end
                START, PARITY, STOP: timer <= tick ? FULL_LD : timer - 1'b1;
                default: ;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH_BITWIDTH(FIFO_DEPTH_BITWIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_data(shreg),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .empty  (empty),
        .full   (full)
    );

    // While full, any rd_en is a real pop, so only a push without rd_en loses data.
    assign overrun_set = push & full & ~rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (overrun_set)        overrun <= 1'b1;
            else if (err_clr)       overrun <= 1'b0;
            if (frame_err_set)      framing_error <= 1'b1;
            else if (err_clr)       framing_error <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)               parity_error <= 1'b0;
        else if (par_err_set)  parity_error <= 1'b1;
        else if (err_clr)      parity_error <= 1'b0;
    end
`endif

endmodule
